// File: rtl/qproc_dispatch_pkg.sv
// rtl/qproc_dispatch_pkg.sv - shared types for the timed port-write dispatcher
// Contents: dispatch_entry_t (queued write), dispatch_state_e (dispatch FSM),
//           LATE_DROP_THR (lateness limit), is_due() (wrap-safe time compare).
package qproc_dispatch_pkg;

  // Entry address field is wider than any practical PA_W so that out-of-range
  // addresses survive the queue and are rejected at pop time.
  localparam int ENTRY_AW      = 16;
  localparam int LATE_DROP_THR = 255;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         tstamp;
    logic [31:0]         dt;
  } dispatch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FIRE
  } dispatch_state_e;

  // Due when (now - t) is non-negative as a signed 32-bit value, so the
  // comparison keeps working across counter wrap-around.
  function automatic logic is_due(input logic [31:0] now, input logic [31:0] t);
    logic [31:0] diff;
    diff = now - t;
    return ~diff[31];
  endfunction

endpackage

// File: rtl/qproc_dispatch_fifo.sv
// rtl/qproc_dispatch_fifo.sv - show-ahead synchronous FIFO of dispatch entries
// Ports: c_clk_i/c_rst_ni clock and sync active-low reset; flush_i sync clear;
//        push_i/push_entry_i write side; pop_i read side; head_o show-ahead
//        head entry; full_o/empty_o/cnt_o occupancy status.
module qproc_dispatch_fifo
  import qproc_dispatch_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic            c_clk_i,
  input  logic            c_rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  dispatch_entry_t push_entry_i,
  input  logic            pop_i,
  output dispatch_entry_t head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [AW:0]     cnt_o
);

  localparam int DEPTH = 2 ** AW;

  dispatch_entry_t r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_cnt;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_do_pop  = pop_i && !w_empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_ff @(posedge c_clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_entry_i;
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (!c_rst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign cnt_o   = r_cnt;

endmodule

// File: rtl/qproc_port_dispatch.sv
// rtl/qproc_port_dispatch.sv - releases queued port writes when their time arrives
// Option: QPROC_DISPATCH_LATE_DROP_EN discards entries more than LATE_DROP_THR
//         cycles late (late_o still pulses, out_vld_o stays 0).
// Ports: c_clk_i/c_rst_ni clock and sync active-low reset; en_i dispatch
//        enable; restart_i sync flush; port_we_i/port_addr_i/port_time_i/
//        port_dt_i core write stream; time_abs_i absolute time; out_vld_o
//        one-hot fire strobe; out_dt_o payload; fifo_cnt_o/fifo_full_o/
//        fifo_empty_o queue status; late_o late pulse; ovf_o/addr_err_o sticky.
module qproc_port_dispatch
  import qproc_dispatch_pkg::*;
#(
  parameter int FIFO_AW      = 3,
  parameter int OUT_PORT_QTY = 4,
  parameter int PA_W         = 4
) (
  input  logic                    c_clk_i,
  input  logic                    c_rst_ni,
  input  logic                    en_i,
  input  logic                    restart_i,
  input  logic                    port_we_i,
  input  logic [PA_W-1:0]         port_addr_i,
  input  logic [31:0]             port_time_i,
  input  logic [31:0]             port_dt_i,
  input  logic [31:0]             time_abs_i,
  output logic [OUT_PORT_QTY-1:0] out_vld_o,
  output logic [31:0]             out_dt_o,
  output logic [FIFO_AW:0]        fifo_cnt_o,
  output logic                    fifo_full_o,
  output logic                    fifo_empty_o,
  output logic                    late_o,
  output logic                    ovf_o,
  output logic                    addr_err_o
);

  dispatch_state_e r_state;
  dispatch_state_e w_state_nxt;

  logic [OUT_PORT_QTY-1:0] r_fire_oh;
  logic [31:0]             r_out_dt;
  logic                    r_fire_late;
  logic                    r_ovf;
  logic                    r_addr_err;

  dispatch_entry_t  w_push_entry;
  dispatch_entry_t  w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [FIFO_AW:0] w_fifo_cnt;
  logic [31:0]      w_lateness;
  logic             w_due;
  logic             w_pop;
  logic             w_addr_ok;
  logic             w_late_drop;

  assign w_push_entry.addr   = ENTRY_AW'(port_addr_i);
  assign w_push_entry.tstamp = port_time_i;
  assign w_push_entry.dt     = port_dt_i;

  qproc_dispatch_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .c_clk_i      (c_clk_i),
    .c_rst_ni     (c_rst_ni),
    .flush_i      (restart_i),
    .push_i       (port_we_i),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .full_o       (w_fifo_full),
    .empty_o      (w_fifo_empty),
    .cnt_o        (w_fifo_cnt)
  );

  assign w_lateness = time_abs_i - w_head.tstamp;
  assign w_due      = is_due(time_abs_i, w_head.tstamp);
  assign w_pop      = (r_state == ST_WAIT) && en_i && w_due && !w_fifo_empty;
  assign w_addr_ok  = (32'(w_head.addr) < 32'(OUT_PORT_QTY));

`ifdef QPROC_DISPATCH_LATE_DROP_EN
  assign w_late_drop = (w_lateness > 32'(LATE_DROP_THR));
`else
  assign w_late_drop = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_fifo_empty) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_pop) w_state_nxt = ST_FIRE;
      ST_FIRE: w_state_nxt = w_fifo_empty ? ST_IDLE : ST_WAIT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk_i) begin
    if (!c_rst_ni || restart_i) begin
      r_state     <= ST_IDLE;
      r_fire_oh   <= '0;
      r_out_dt    <= '0;
      r_fire_late <= 1'b0;
      r_ovf       <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (port_we_i && w_fifo_full && !w_pop) r_ovf <= 1'b1;
      if (w_pop) begin
        // Address-rejected entries are reported via addr_err_o only.
        r_fire_late <= w_addr_ok && (w_lateness != '0);
        if (w_addr_ok && !w_late_drop) begin
          r_fire_oh <= OUT_PORT_QTY'(1) << w_head.addr;
          r_out_dt  <= w_head.dt;
        end else begin
          r_fire_oh <= '0;
        end
        if (!w_addr_ok) r_addr_err <= 1'b1;
      end
    end
  end

  assign out_vld_o    = (r_state == ST_FIRE) ? r_fire_oh : '0;
  assign late_o       = (r_state == ST_FIRE) && r_fire_late;
  assign out_dt_o     = r_out_dt;
  assign fifo_cnt_o   = w_fifo_cnt;
  assign fifo_full_o  = w_fifo_full;
  assign fifo_empty_o = w_fifo_empty;
  assign ovf_o        = r_ovf;
  assign addr_err_o   = r_addr_err;

endmodule

// File: tb/tb_qproc_port_dispatch.sv
// tb/tb_qproc_port_dispatch.sv - scoreboard bench for qproc_port_dispatch
module tb_qproc_port_dispatch;

  localparam int AW = 3;
  localparam int NP = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, restart, we;
  logic [PW-1:0] addr;
  logic [31:0]   ptime, pdt, tabs;
  logic [NP-1:0] out_vld;
  logic [31:0]   out_dt;
  logic [AW:0]   cnt;
  logic          full, empty, late, ovf, aerr;

  always #5 clk = ~clk;

  qproc_port_dispatch #(
    .FIFO_AW      (AW),
    .OUT_PORT_QTY (NP),
    .PA_W         (PW)
  ) dut (
    .c_clk_i      (clk),
    .c_rst_ni     (rst_n),
    .en_i         (en),
    .restart_i    (restart),
    .port_we_i    (we),
    .port_addr_i  (addr),
    .port_time_i  (ptime),
    .port_dt_i    (pdt),
    .time_abs_i   (tabs),
    .out_vld_o    (out_vld),
    .out_dt_o     (out_dt),
    .fifo_cnt_o   (cnt),
    .fifo_full_o  (full),
    .fifo_empty_o (empty),
    .late_o       (late),
    .ovf_o        (ovf),
    .addr_err_o   (aerr)
  );

  typedef struct {
    int unsigned a;
    logic [31:0] t;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;
  int   n_pass    = 0;
  int   n_total   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tabs = tabs + 1;
  endtask

  task automatic push(input logic [PW-1:0] a, input logic [31:0] t, input logic [31:0] d,
                      input bit track);
    exp_t e;
    we = 1'b1; addr = a; ptime = t; pdt = d;
    if (track) begin
      e.a = a; e.t = t; e.d = d;
      exp_q.push_back(e);
      model_cnt++;
    end
    tick();
    we = 1'b0;
  endtask

  task automatic wait_event(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((|out_vld) || late) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    check("drain_done", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Reference: fires leave in push order; each must be due at its pop cycle
  // (the cycle before the strobe), hit port 1<<addr with its payload, and be
  // flagged late when the pop-cycle time differs from its scheduled time.
  logic [31:0] prev_tabs = '0;
  initial begin
    exp_t        e;
    logic [31:0] lat;
    bit          drop;
    forever begin
      @(negedge clk);
      if ((|out_vld) || late) begin
        if (exp_q.size() == 0) begin
          check("spurious_fire", {out_vld, late}, 0);
        end else begin
          e = exp_q.pop_front();
          model_cnt--;
          lat  = prev_tabs - e.t;
          drop = 1'b0;
`ifdef QPROC_DISPATCH_LATE_DROP_EN
          drop = (lat > 32'd255);
`endif
          check("fire_due", lat[31], 0);
          check("fire_port", out_vld, drop ? 0 : (64'd1 << e.a));
          if (!drop) check("fire_dt", out_dt, e.d);
          check("fire_late", late, prev_tabs != e.t);
        end
      end
      prev_tabs = tabs;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] d_start [6] = '{32'd50, 32'd20, 32'd400, 32'hFFFF_FFE0, 32'hFFFF_FFF8, 32'd2};
  logic [31:0] d_time  [6] = '{32'd100, 32'd10, 32'd10, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFE};
  logic [31:0] d_fire  [6] = '{32'd101, 32'd23, 32'd403, 32'hFFFF_FFF1, 32'd5, 32'd5};
  logic [3:0]  d_addr  [6] = '{4'd2, 4'd0, 4'd1, 4'd3, 4'd2, 4'd1};

  initial begin
    bit          got;
    logic [31:0] base;
    int          off;
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; we = 1'b0;
    addr = '0; ptime = '0; pdt = '0; tabs = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_vld", out_vld, 0);
    check("rst_dt", out_dt, 0);
    check("rst_cnt", cnt, 0);
    check("rst_flags", {full, empty, late, ovf, aerr}, 5'b01000);
    rst_n = 1'b1;
    tick();

    // Directed timing cases, including wrap-around of the time counter.
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (2) tick();
      tabs = d_start[i];
      push(d_addr[i], d_time[i], (i == 0) ? 32'hA5A5 : $urandom, 1'b1);
      wait_event(300, got);
      check($sformatf("dir%0d_seen", i), got, 1);
      check($sformatf("dir%0d_fire_time", i), tabs, d_fire[i]);
      tick();
    end

    // Overflow: fill with dispatch frozen, one extra push is lost.
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 8; i++) push(PW'(i % NP), tabs, $urandom, 1'b1);
    push(4'd1, tabs, 32'hDEAD, 1'b0);
    @(negedge clk);
    check("ovf_full", full, 1);
    check("ovf_flag", ovf, 1);
    check("ovf_cnt", cnt, 8);
    en = 1'b1;
    drain(100);
    check("ovf_drained_empty", empty, 1);

    // Bad address: discarded on time (not late), following entry still fires.
    base = tabs;
    push(4'd7, base + 32'd5, 32'h1111, 1'b0);
    push(4'd1, tabs, 32'h2222, 1'b1);
    drain(100);
    check("addr_err_flag", aerr, 1);

    // Restart while an entry is on the output with three more queued.
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(PW'(i), tabs, $urandom, 1'b1);
    en = 1'b1;
    wait_event(50, got);
    check("rs_fire_seen", got, 1);
    check("rs_cnt_before", cnt, 3);
    restart = 1'b1;
    tick();
    @(negedge clk);
    check("rs_vld", out_vld, 0);
    check("rs_cnt", cnt, 0);
    check("rs_flags", {full, empty, late, ovf, aerr}, 5'b01000);
    restart = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    repeat (2) tick();

    // Randomized traffic; pushes only while the model proves a free slot.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom % 4) != 0;
      if (model_cnt < 8 && ($urandom % 2) == 1) begin
        off = int'($urandom_range(40)) - 20;
        push(PW'($urandom_range(NP - 1)), tabs + 32'(off), $urandom, 1'b1);
      end else begin
        tick();
      end
    end
    en = 1'b1;
    drain(500);
    @(negedge clk);
    check("final_empty", empty, 1);
    check("final_cnt", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
